// File: rtl/oc_dispatch_sched.sv
// Dispatch scheduler for the 4-entry operand-collector array.
// Issues at most one one-hot ALU grant and at most one one-hot MEM grant per cycle.
// Each grant is registered and also serves as the read enable for its collector.
// ALU issue is blocked while ALU_Stall is high.
// MEM issue is blocked while no memory-unit credits are free.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   RDY_OC             per-collector ready (operands present, entry valid)
//   MemOp_OC           per-collector "holds a memory op"
//   ALU_Stall          ALU pipeline cannot accept an op this cycle
//   MEM_Credit_Return  one-cycle pulse, memory unit freed a slot
//   ALU_Grt_Sched_OC   registered one-hot ALU grant / read enable
//   MEM_Grt_Sched_OC   registered one-hot MEM grant / read enable
//   MEM_Credits        free MEM credits
//   Credit_Err         sticky: return received while credits were already full
module oc_dispatch_sched #(
  parameter int unsigned NUM_OC      = 4,
  parameter int unsigned MEM_CREDITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_OC-1:0] RDY_OC,
  input  logic [NUM_OC-1:0] MemOp_OC,
  input  logic              ALU_Stall,
  input  logic              MEM_Credit_Return,
  output logic [NUM_OC-1:0] ALU_Grt_Sched_OC,
  output logic [NUM_OC-1:0] MEM_Grt_Sched_OC,
  output logic [2:0]        MEM_Credits,
  output logic              Credit_Err
);

  // Pointer arithmetic relies on natural wrap, so NUM_OC must stay a power of two.
  localparam int unsigned PtrW = $clog2(NUM_OC);
  localparam logic [2:0]  CreditMax = 3'(MEM_CREDITS);

  logic [NUM_OC-1:0] alu_grt_q, alu_grt_d;
  logic [NUM_OC-1:0] mem_grt_q, mem_grt_d;
  logic [PtrW-1:0]   alu_ptr_q, alu_ptr_d;
  logic [PtrW-1:0]   mem_ptr_q, mem_ptr_d;
  logic [2:0]        credits_q, credits_d;
  logic              err_q, err_d;

  logic [NUM_OC-1:0] masked, alu_req, mem_req;

  // A collector granted last cycle still shows RDY this cycle; hide it so it is not re-picked.
  assign masked  = RDY_OC & ~(alu_grt_q | mem_grt_q);
  assign alu_req = masked & ~MemOp_OC;
  assign mem_req = masked & MemOp_OC;

  // Round-robin pick: take the first request at or above the pointer, wrapping around.
  always_comb begin
    logic            found;
    logic [PtrW-1:0] idx;
    alu_grt_d = '0;
    alu_ptr_d = alu_ptr_q;
    found     = 1'b0;
    idx       = '0;
    if (!ALU_Stall) begin
      for (int i = 0; i < NUM_OC; i++) begin
        idx = alu_ptr_q + PtrW'(i);
        if (!found && alu_req[idx]) begin
          found          = 1'b1;
          alu_grt_d[idx] = 1'b1;
          alu_ptr_d      = idx + PtrW'(1);
        end
      end
    end
  end

  always_comb begin
    logic            found;
    logic [PtrW-1:0] idx;
    mem_grt_d = '0;
    mem_ptr_d = mem_ptr_q;
    found     = 1'b0;
    idx       = '0;
    if (credits_q != 3'd0) begin
      for (int i = 0; i < NUM_OC; i++) begin
        idx = mem_ptr_q + PtrW'(i);
        if (!found && mem_req[idx]) begin
          found          = 1'b1;
          mem_grt_d[idx] = 1'b1;
          mem_ptr_d      = idx + PtrW'(1);
        end
      end
    end
  end

  // A grant consumes a credit on the same edge that registers the grant.
  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    unique case ({|mem_grt_d, MEM_Credit_Return})
      2'b10: credits_d = credits_q - 3'd1;
      2'b01: begin
        if (credits_q == CreditMax) err_d = 1'b1;
        else                        credits_d = credits_q + 3'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_grt_q <= '0;
      mem_grt_q <= '0;
      alu_ptr_q <= '0;
      mem_ptr_q <= '0;
      credits_q <= CreditMax;
      err_q     <= 1'b0;
    end else begin
      alu_grt_q <= alu_grt_d;
      mem_grt_q <= mem_grt_d;
      alu_ptr_q <= alu_ptr_d;
      mem_ptr_q <= mem_ptr_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  assign ALU_Grt_Sched_OC = alu_grt_q;
  assign MEM_Grt_Sched_OC = mem_grt_q;
  assign MEM_Credits      = credits_q;
  assign Credit_Err       = err_q;

endmodule
